// File: rtl/uart_gonderim_fifo.sv
// Transmit-side circular byte FIFO feeding the UART transmitter; also holds a
// stable copy of the last popped byte for the whole outgoing frame.
module uart_gonderim_fifo #(
  parameter  int DERINLIK  = 16,
  localparam int ADRES_BIT = $clog2(DERINLIK)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               temizle_i,
  input  logic               yaz_gecerli_i,
  input  logic [7:0]         yaz_veri_i,
  output logic               yaz_hazir_o,
  output logic               veri_gecerli_o,
  input  logic               consume_i,
  output logic [7:0]         bas_veri_o,
  output logic [7:0]         gonderilen_veri_o,
  output logic [ADRES_BIT:0] doluluk_o,
  output logic               bos_o,
  output logic               dolu_o,
  output logic               tasma_o
);

  localparam logic [ADRES_BIT:0]   DOLU_SAYI = (ADRES_BIT+1)'(DERINLIK);
  localparam logic [ADRES_BIT:0]   SAYAC_BIR = (ADRES_BIT+1)'(1);
  localparam logic [ADRES_BIT-1:0] PTR_BIR   = ADRES_BIT'(1);

  logic [7:0]           mem_q [DERINLIK];
  logic [ADRES_BIT-1:0] yaz_ptr_q, yaz_ptr_d;
  logic [ADRES_BIT-1:0] oku_ptr_q, oku_ptr_d;
  logic [ADRES_BIT:0]   sayac_q, sayac_d;
  logic                 tasma_q, tasma_d;
  logic [7:0]           gonderilen_q, gonderilen_d;
  logic                 pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside an accepted pop; there is no fall-through on empty.
  assign pop_ok  = consume_i && (sayac_q != '0);
  assign push_ok = yaz_gecerli_i && ((sayac_q != DOLU_SAYI) || pop_ok);

  always_comb begin
    yaz_ptr_d    = yaz_ptr_q;
    oku_ptr_d    = oku_ptr_q;
    sayac_d      = sayac_q;
    tasma_d      = tasma_q;
    gonderilen_d = gonderilen_q;
    if (temizle_i) begin
      // Flush leaves the held byte alone so a frame in flight stays intact.
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
      sayac_d   = '0;
      tasma_d   = 1'b0;
    end else begin
      if (push_ok) begin
        yaz_ptr_d = yaz_ptr_q + PTR_BIR;
      end
      if (pop_ok) begin
        oku_ptr_d    = oku_ptr_q + PTR_BIR;
        gonderilen_d = mem_q[oku_ptr_q];
      end
      if (yaz_gecerli_i && !push_ok) begin
        tasma_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   sayac_d = sayac_q + SAYAC_BIR;
        2'b01:   sayac_d = sayac_q - SAYAC_BIR;
        default: sayac_d = sayac_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr_q    <= '0;
      oku_ptr_q    <= '0;
      sayac_q      <= '0;
      tasma_q      <= 1'b0;
      gonderilen_q <= '0;
    end else begin
      yaz_ptr_q    <= yaz_ptr_d;
      oku_ptr_q    <= oku_ptr_d;
      sayac_q      <= sayac_d;
      tasma_q      <= tasma_d;
      gonderilen_q <= gonderilen_d;
    end
  end

  // Storage carries no reset; contents are meaningful only below sayac_q.
  always_ff @(posedge clk_i) begin
    if (push_ok && !temizle_i) begin
      mem_q[yaz_ptr_q] <= yaz_veri_i;
    end
  end

  assign bas_veri_o        = mem_q[oku_ptr_q];
  assign gonderilen_veri_o = gonderilen_q;
  assign doluluk_o         = sayac_q;
  assign bos_o             = (sayac_q == '0);
  assign dolu_o            = (sayac_q == DOLU_SAYI);
  assign veri_gecerli_o    = !bos_o;
  assign yaz_hazir_o       = !dolu_o;
  assign tasma_o           = tasma_q;

endmodule

// File: tb/tb_uart_gonderim_fifo.sv
// Directed bench for uart_gonderim_fifo with a queue-based occupancy model.
module tb_uart_gonderim_fifo;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       temizle_i;
  logic       yaz_gecerli_i;
  logic [7:0] yaz_veri_i;
  logic       consume_i;
  logic       yaz_hazir_o;
  logic       veri_gecerli_o;
  logic [7:0] bas_veri_o;
  logic [7:0] gonderilen_veri_o;
  logic [4:0] doluluk_o;
  logic       bos_o;
  logic       dolu_o;
  logic       tasma_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_gond;
  logic       m_tasma;

  always #5 clk_i = ~clk_i;

  uart_gonderim_fifo #(.DERINLIK(16)) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .temizle_i         (temizle_i),
    .yaz_gecerli_i     (yaz_gecerli_i),
    .yaz_veri_i        (yaz_veri_i),
    .yaz_hazir_o       (yaz_hazir_o),
    .veri_gecerli_o    (veri_gecerli_o),
    .consume_i         (consume_i),
    .bas_veri_o        (bas_veri_o),
    .gonderilen_veri_o (gonderilen_veri_o),
    .doluluk_o         (doluluk_o),
    .bos_o             (bos_o),
    .dolu_o            (dolu_o),
    .tasma_o           (tasma_o)
  );

  task automatic kontrol(input string tag, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_cmp++;
    if (gozlenen !== beklenen) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, gozlenen, beklenen);
    end
  endtask

  task automatic model_kontrol();
    kontrol("doluluk", 32'(doluluk_o), 32'(m_q.size()));
    kontrol("bos", 32'(bos_o), 32'(m_q.size() == 0));
    kontrol("dolu", 32'(dolu_o), 32'(m_q.size() == 16));
    kontrol("veri_gecerli", 32'(veri_gecerli_o), 32'(m_q.size() != 0));
    kontrol("yaz_hazir", 32'(yaz_hazir_o), 32'(m_q.size() != 16));
    kontrol("tasma", 32'(tasma_o), 32'(m_tasma));
    kontrol("gonderilen", 32'(gonderilen_veri_o), 32'(m_gond));
    if (m_q.size() != 0) kontrol("bas_veri", 32'(bas_veri_o), 32'(m_q[0]));
  endtask

  // One clock: drive, take the edge, advance the model, check just after.
  task automatic cyc(input logic push, input logic [7:0] d, input logic pop,
                     input logic flush);
    logic pop_ok, push_ok;
    yaz_gecerli_i = push;
    yaz_veri_i    = d;
    consume_i     = pop;
    temizle_i     = flush;
    @(posedge clk_i);
    if (flush) begin
      m_q.delete();
      m_tasma = 1'b0;
    end else begin
      pop_ok  = pop && (m_q.size() != 0);
      push_ok = push && ((m_q.size() != 16) || pop_ok);
      if (pop_ok) m_gond = m_q.pop_front();
      if (push_ok) m_q.push_back(d);
      else if (push) m_tasma = 1'b1;
    end
    #1;
    yaz_gecerli_i = 1'b0;
    consume_i     = 1'b0;
    temizle_i     = 1'b0;
    model_kontrol();
  endtask

  initial begin
    rstn_i = 1'b0; temizle_i = 1'b0; yaz_gecerli_i = 1'b0;
    yaz_veri_i = 8'h00; consume_i = 1'b0;
    m_gond = 8'h00; m_tasma = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    model_kontrol();

    // Three pushes, one pop, then an asynchronous reset between edges.
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    kontrol("uc_itme_doluluk", 32'(doluluk_o), 32'd3);
    cyc(0, 8'h00, 1, 0);
    kontrol("ilk_pop", 32'(gonderilen_veri_o), 32'h11);
    #3 rstn_i = 1'b0;
    #1;
    kontrol("rst_doluluk", 32'(doluluk_o), 32'd0);
    kontrol("rst_bos", 32'(bos_o), 32'd1);
    kontrol("rst_yaz_hazir", 32'(yaz_hazir_o), 32'd1);
    kontrol("rst_tasma", 32'(tasma_o), 32'd0);
    kontrol("rst_gonderilen", 32'(gonderilen_veri_o), 32'h00);
    m_q.delete(); m_gond = 8'h00; m_tasma = 1'b0;
    #2 rstn_i = 1'b1;

    // Ordering and pointer wrap: 24 bytes with a pop on every odd cycle.
    for (int i = 0; i < 24; i++) cyc(1, 8'(i), (i % 2) == 1, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 1, 0);
    end
    kontrol("sira_son", 32'(gonderilen_veri_o), 32'h17);
    kontrol("sira_bos", 32'(bos_o), 32'd1);

    // Full and overflow.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    kontrol("tasma_bayrak", 32'(tasma_o), 32'd1);
    kontrol("tasma_doluluk", 32'(doluluk_o), 32'd16);
    kontrol("tasma_dolu", 32'(dolu_o), 32'd1);
    cyc(1, 8'hBB, 1, 0);
    kontrol("dolu_itpop_doluluk", 32'(doluluk_o), 32'd16);
    kontrol("dolu_itpop_gond", 32'(gonderilen_veri_o), 32'h80);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    kontrol("bb_son", 32'(gonderilen_veri_o), 32'hBB);

    // Empty edges.
    cyc(0, 8'h00, 1, 0);
    kontrol("bos_pop_gond", 32'(gonderilen_veri_o), 32'hBB);
    cyc(1, 8'h5A, 1, 0);
    kontrol("bos_itpop_doluluk", 32'(doluluk_o), 32'd1);
    kontrol("bos_itpop_bas", 32'(bas_veri_o), 32'h5A);
    kontrol("bos_itpop_gond", 32'(gonderilen_veri_o), 32'hBB);

    // Flush priority with five entries and 0x33 held; tasma still set.
    cyc(1, 8'h33, 1, 0);
    cyc(0, 8'h00, 1, 0);
    kontrol("temizle_oncesi_gond", 32'(gonderilen_veri_o), 32'h33);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'hEE, 1, 1);
    kontrol("temizle_doluluk", 32'(doluluk_o), 32'd0);
    kontrol("temizle_tasma", 32'(tasma_o), 32'd0);
    kontrol("temizle_gond", 32'(gonderilen_veri_o), 32'h33);
    cyc(1, 8'h77, 0, 0);
    kontrol("temizle_sonrasi_bas", 32'(bas_veri_o), 32'h77);
    cyc(0, 8'h00, 1, 0);
    kontrol("temizle_sonrasi_gond", 32'(gonderilen_veri_o), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_gonderim_fifo.md
# uart_gonderim_fifo

Transmit-side byte buffer sitting directly upstream of the UART transmitter (`uart_verici`). It accepts bytes from the peripheral bus register interface, stores them in a circular FIFO, and presents `!empty` plus a pop handshake to the transmitter. The transmitter samples its data input for the whole frame after popping, so this block also provides a stable copy of the last popped byte, held until the next pop.

## Interface
- `DERINLIK`, 16: FIFO depth in bytes; power of two, ≥ 2.
- `ADRES_BIT`, $clog2(DERINLIK): pointer width (derived, not overridden).

Ports:
- `clk_i` input 1: single clock.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `temizle_i` input 1: synchronous flush.
- `yaz_gecerli_i` input 1: bus push request.
- `yaz_veri_i` input 8: byte to push.
- `yaz_hazir_o` output 1: FIFO not full (`!dolu_o`).
- `veri_gecerli_o` output 1: FIFO not empty; drives transmitter `veri_gecerli_i`.
- `consume_i` input 1: pop strobe from transmitter `consume_o`.
- `bas_veri_o` output 8: current head byte; valid only while `veri_gecerli_o`=1.
- `gonderilen_veri_o` output 8: byte latched at the last accepted pop; drives transmitter `gelen_veri_i`.
- `doluluk_o` output ADRES_BIT+1: occupancy, 0..DERINLIK.
- `bos_o` / `dolu_o` output 1 each: empty / full flags.
- `tasma_o` output 1: sticky overflow, push dropped while full.

## Operation
- Storage: DERINLIK×8 register array; write pointer `yaz_ptr`, read pointer `oku_ptr` (ADRES_BIT bits, wrap modulo DERINLIK); count register `sayac` (ADRES_BIT+1 bits).
- Pop accepted (`pop_ok`) = `consume_i && sayac != 0`. Consume on empty is ignored: no pointer, count, or `gonderilen_veri_o` change; no error.
- Push accepted (`push_ok`) = `yaz_gecerli_i && (sayac != DERINLIK || pop_ok)`. A push to a full FIFO in the same cycle as an accepted pop is accepted.
- Push while full without pop: byte dropped, `tasma_o` ← 1.
- On `push_ok`: mem[yaz_ptr] ← `yaz_veri_i`, then `yaz_ptr`+1.
- On `pop_ok`: `gonderilen_veri_o` ← mem[oku_ptr], then `oku_ptr`+1.
- Count update: push only gives +1; pop only gives −1; both or neither leave it unchanged.
- Empty with simultaneous push and consume: push is accepted; consume is ignored because there is no fall-through.
- `temizle_i`=1 has priority over push and pop in that cycle:
  - Pointers, count, and `tasma_o` go to 0.
  - `gonderilen_veri_o` keeps its value, so a frame in flight is not corrupted.
  - Memory contents are don't-care.
- `tasma_o` clears only on `temizle_i` or reset.
- `bas_veri_o` = mem[oku_ptr], a combinational read of registered state.
- `bos_o` = (`sayac`==0), `dolu_o` = (`sayac`==DERINLIK), `veri_gecerli_o` = `!bos_o`, `yaz_hazir_o` = `!dolu_o`, `doluluk_o` = `sayac`.

## Timing
- Reset (async assert, sync release by the clock edge):
  - Pointers, `sayac`, `tasma_o`, and `gonderilen_veri_o` go to 0.
  - So `bos_o`=1, `veri_gecerli_o`=0, `dolu_o`=0, `yaz_hazir_o`=1, `doluluk_o`=0.
  - Reset mid-transfer discards all contents immediately.
- Push-to-visible latency: 1 cycle. A byte pushed at edge N raises `veri_gecerli_o` and appears on `bas_veri_o` after edge N.
- Pop: `consume_i` sampled at edge N. After N, `gonderilen_veri_o` holds the popped byte, and `bas_veri_o`/`veri_gecerli_o` reflect the next entry.
- The transmitter's `consume_o` is combinational from `veri_gecerli_o`. This block therefore has no combinational path from `consume_i` to `veri_gecerli_o`, so there is no loop.
- `gonderilen_veri_o` is stable from the edge after a pop until the next accepted pop. This covers a full 10-bit frame.
- Back-to-back pops on consecutive cycles are legal; each drains one entry.
- All outputs are registered or decoded from registers only; no input-to-output combinational paths.

## Test plan
- Reset: assert `rstn_i`=0 asynchronously mid-cycle after 3 pushes -> immediately `doluluk_o`=0, `bos_o`=1, `yaz_hazir_o`=1, `tasma_o`=0, `gonderilen_veri_o`=0x00.
- Ordering/wrap: push 0x00..0x17 interleaved with pops (DERINLIK=16, 24 bytes total, forcing pointer wrap) -> popped sequence equals pushed sequence. `gonderilen_veri_o` is held unchanged between pops.
- Full/overflow: push 16 bytes, then push 0xAA without consume -> `dolu_o`=1, 0xAA dropped, `tasma_o`=1, `doluluk_o`=16. Then push 0xBB with `consume_i`=1 -> accepted, count stays 16, and 0xBB pops last.
- Empty edges: `consume_i`=1 on empty -> no change. Push 0x5A with `consume_i`=1 on empty -> `doluluk_o`=1, `bas_veri_o`=0x5A, `gonderilen_veri_o` unchanged.
- Flush priority: with 5 entries and `gonderilen_veri_o`=0x33, assert `temizle_i` with push and consume in the same cycle -> count 0, `tasma_o`=0, `gonderilen_veri_o`=0x33.
- Integration with `uart_verici` (`baud_div_i`=4): push 0x55, 0xA3 -> `tx_o` shows two correct LSB-first frames. Data stays stable through each frame.
